// File: rtl/sig_ctrl.sv
// rtl/sig_ctrl.sv - signature controller: run/drain/done sequencing and dump record FIFO
// Sig writes steer the run FSM (stop) or emit ireg/stream dump records through a 2-entry FIFO.
module sig_ctrl #(
  parameter int ADDR_WIDTH  = 21,
  parameter int DATA_WIDTH  = 128,
  parameter int STOP_ADDR   = 0,
  parameter int IREG_ADDR   = 1,
  parameter int STREAM_ADDR = 2,
  parameter int STOP_DRAIN  = 50,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run_en_i,
  input  logic [CNT_WIDTH-1:0]  simlen_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_t0_i,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic                  dump_kind_o,
  output logic [7:0]            dump_id_o,
  output logic [63:0]           dump_value_o,
  output logic [63:0]           dump_value_t0_o,
  output logic                  dump_tainted_o,
  output logic [1:0]            state_o,
  output logic                  done_o,
  output logic                  done_cause_o,
  output logic [CNT_WIDTH-1:0]  step_o,
  output logic                  overflow_o
);

  localparam int DRAIN_W = $clog2(STOP_DRAIN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic        kind;
    logic [7:0]  id;
    logic [63:0] value;
    logic [63:0] value_t0;
  } rec_t;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] step_q, step_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 cause_q, cause_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           ireg_id_q, ireg_id_d;
  logic [7:0]           stream_id_q, stream_id_d;
  rec_t                 slot0_q, slot0_d;
  rec_t                 slot1_q, slot1_d;
  logic [1:0]           cnt_q, cnt_d;

  logic sig_wr, hit_stop, hit_ireg, hit_stream, limit_hit;
  logic dump_wr, push, pop;
  rec_t new_rec, head;

  logic unused_wdata_hi;
  assign unused_wdata_hi = ^{mem_wdata_i[DATA_WIDTH-1:64], mem_wdata_t0_i[DATA_WIDTH-1:64]};

  assign sig_wr     = mem_req_i & mem_we_i;
  assign hit_stop   = sig_wr && (mem_addr_i == ADDR_WIDTH'(STOP_ADDR));
  assign hit_ireg   = sig_wr && (mem_addr_i == ADDR_WIDTH'(IREG_ADDR));
  assign hit_stream = sig_wr && (mem_addr_i == ADDR_WIDTH'(STREAM_ADDR));
  assign limit_hit  = (simlen_i != '0) && (step_q == simlen_i - CNT_WIDTH'(1));

  assign dump_wr = (state_q == RUN) && (hit_ireg || hit_stream);
  assign pop     = (cnt_q != 2'd0) && dump_ready_i;
  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push    = dump_wr && ((cnt_q != 2'd2) || pop);

  always_comb begin
    new_rec          = '0;
    new_rec.kind     = hit_stream;
    new_rec.id       = hit_stream ? stream_id_q : ireg_id_q;
    new_rec.value    = mem_wdata_i[63:0];
    new_rec.value_t0 = mem_wdata_t0_i[63:0];
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    drain_d = drain_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (run_en_i) state_d = RUN;
      end
      RUN: begin
        step_d = step_q + CNT_WIDTH'(1);
        if (limit_hit) begin
          state_d = DONE;
          cause_d = 1'b1;
        end else if (hit_stop) begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(STOP_DRAIN);
        end
      end
      DRAIN: begin
        step_d = step_q + CNT_WIDTH'(1);
        if (limit_hit) begin
          state_d = DONE;
          cause_d = 1'b1;
        end else if (drain_q == '0) begin
          state_d = DONE;
          cause_d = 1'b0;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q | (dump_wr & ~push);
    ireg_id_d   = ireg_id_q;
    stream_id_d = stream_id_q;
    if (dump_wr && hit_ireg)   ireg_id_d   = ireg_id_q + 8'd1;
    if (dump_wr && hit_stream) stream_id_d = stream_id_q + 8'd1;
    unique case ({push, pop})
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) slot0_d = new_rec;
        else               slot1_d = new_rec;
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          slot0_d = new_rec;
        end else begin
          slot0_d = slot1_q;
          slot1_d = new_rec;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      step_q      <= '0;
      drain_q     <= '0;
      cause_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ireg_id_q   <= 8'd1;
      stream_id_q <= 8'd0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      drain_q     <= drain_d;
      cause_q     <= cause_d;
      ovf_q       <= ovf_d;
      ireg_id_q   <= ireg_id_d;
      stream_id_q <= stream_id_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      cnt_q       <= cnt_d;
    end
  end

  // Stale slot contents are masked so idle dump outputs read as zero.
  assign head            = dump_valid_o ? slot0_q : '0;
  assign dump_valid_o    = (cnt_q != 2'd0);
  assign dump_kind_o     = head.kind;
  assign dump_id_o       = head.id;
  assign dump_value_o    = head.value;
  assign dump_value_t0_o = head.value_t0;
  assign dump_tainted_o  = |head.value_t0;
  assign state_o         = state_q;
  assign done_o          = (state_q == DONE);
  assign done_cause_o    = cause_q;
  assign step_o          = step_q;
  assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_sig_ctrl.sv
// tb/tb_sig_ctrl.sv - self-checking bench for sig_ctrl
module tb_sig_ctrl;
  localparam int STOP_DRAIN = 50;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         run_en_i = 1'b0;
  logic [31:0]  simlen_i = '0;
  logic         mem_req_i = 1'b0, mem_we_i = 1'b0;
  logic [20:0]  mem_addr_i = '0;
  logic [127:0] mem_wdata_i = '0, mem_wdata_t0_i = '0;
  logic         dump_valid_o, dump_ready_i = 1'b0;
  logic         dump_kind_o, dump_tainted_o;
  logic [7:0]   dump_id_o;
  logic [63:0]  dump_value_o, dump_value_t0_o;
  logic [1:0]   state_o;
  logic         done_o, done_cause_o, overflow_o;
  logic [31:0]  step_o;

  sig_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .run_en_i(run_en_i), .simlen_i(simlen_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wdata_t0_i(mem_wdata_t0_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_kind_o(dump_kind_o), .dump_id_o(dump_id_o), .dump_value_o(dump_value_o),
    .dump_value_t0_o(dump_value_t0_o), .dump_tainted_o(dump_tainted_o),
    .state_o(state_o), .done_o(done_o), .done_cause_o(done_cause_o),
    .step_o(step_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Model: run phase as an integer, records in a queue, drain measured in steps since the stop.
  typedef struct packed {
    bit        kind;
    bit [7:0]  id;
    bit [63:0] v;
    bit [63:0] t;
  } rec_t;

  rec_t   m_q[$];
  rec_t   r, e;
  int     m_state, m_iid, m_sid;
  longint m_step, m_stop_step;
  bit     m_cause, m_ovf, sw, lim;

  always @(posedge clk) begin
    if (!rst_ni) begin
      m_state = 0; m_step = 0; m_stop_step = 0; m_cause = 0; m_ovf = 0;
      m_iid = 1; m_sid = 0; m_q.delete();
    end else begin
      sw  = mem_req_i && mem_we_i;
      lim = (simlen_i != 0) && (longint'(simlen_i) - 1 == m_step);
      if (m_q.size() != 0 && dump_ready_i) void'(m_q.pop_front());
      if (m_state == 1 && sw && (mem_addr_i == 1 || mem_addr_i == 2)) begin
        r.kind = (mem_addr_i == 2);
        r.id   = r.kind ? 8'(m_sid) : 8'(m_iid);
        r.v    = mem_wdata_i[63:0];
        r.t    = mem_wdata_t0_i[63:0];
        if (r.kind) m_sid = (m_sid + 1) % 256;
        else        m_iid = (m_iid + 1) % 256;
        if (m_q.size() < 2) m_q.push_back(r);
        else m_ovf = 1;
      end
      if (m_state == 0) begin
        if (run_en_i) m_state = 1;
      end else if (m_state == 1 || m_state == 2) begin
        if (lim) begin
          m_state = 3; m_cause = 1;
        end else if (m_state == 1 && sw && mem_addr_i == 0) begin
          m_state = 2; m_stop_step = m_step;
        end else if (m_state == 2 && m_step == m_stop_step + STOP_DRAIN + 1) begin
          m_state = 3; m_cause = 0;
        end
        m_step++;
      end
    end
  end

  always @(negedge clk) begin
    e = (m_q.size() != 0) ? m_q[0] : '0;
    chk("state", 64'(state_o), 64'(m_state));
    chk("done", 64'(done_o), 64'(m_state == 3));
    chk("cause", 64'(done_cause_o), 64'(m_cause));
    chk("step", 64'(step_o), 64'(m_step));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("valid", 64'(dump_valid_o), 64'(m_q.size() != 0));
    chk("kind", 64'(dump_kind_o), 64'(e.kind));
    chk("id", 64'(dump_id_o), 64'(e.id));
    chk("value", dump_value_o, e.v);
    chk("value_t0", dump_value_t0_o, e.t);
    chk("tainted", 64'(dump_tainted_o), 64'(|e.t));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle_bus();
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_wdata_t0_i = '0;
  endtask

  task automatic sig_write(input int addr, input logic [63:0] v, input logic [63:0] t);
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 21'(addr);
    mem_wdata_i = {64'hDEAD_BEEF_0000_FFFF, v};
    mem_wdata_t0_i = {64'hFFFF_FFFF_FFFF_FFFF, t};
  endtask

  task automatic do_reset();
    rst_ni = 0; run_en_i = 0; dump_ready_i = 0; idle_bus();
    tick(2);
    rst_ni = 1;
  endtask

  task automatic start_run(input logic [31:0] len);
    simlen_i = len; run_en_i = 1;
    tick();
    run_en_i = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    do_reset();
    chk("rst_state", 64'(state_o), 0);
    chk("rst_valid", 64'(dump_valid_o), 0);
    chk("rst_step", 64'(step_o), 0);

    // SIMLEN ends the run after the edge at step 9
    start_run(10);
    chk("s028_run", 64'(state_o), 1);
    chk("s028_step0", 64'(step_o), 0);
    wait_done(n);
    chk("s028_edges", 64'(n), 10);
    chk("s028_state", 64'(state_o), 3);
    chk("s028_cause", 64'(done_cause_o), 1);

    // stop at step 5, then drain of 51 edges; ireg write in drain is ignored
    do_reset();
    start_run(0);
    tick(5);
    chk("s029_step5", 64'(step_o), 5);
    sig_write(0, 64'h1234, 0);
    tick();
    chk("s029_drain", 64'(state_o), 2);
    sig_write(1, 64'h77, 0);
    tick();
    idle_bus();
    chk("s029_norec", 64'(dump_valid_o), 0);
    wait_done(n);
    chk("s029_edges", 64'(n), 50);
    chk("s029_cause", 64'(done_cause_o), 0);

    // three ireg writes streamed out with ready high
    do_reset();
    start_run(0);
    dump_ready_i = 1;
    sig_write(1, 64'hA, 64'h0);
    tick();
    chk("s030_id1", 64'(dump_id_o), 1);
    chk("s030_v1", dump_value_o, 64'hA);
    chk("s030_t1", 64'(dump_tainted_o), 0);
    sig_write(1, 64'hB, 64'h0);
    tick();
    chk("s030_id2", 64'(dump_id_o), 2);
    chk("s030_v2", dump_value_o, 64'hB);
    chk("s030_t2", 64'(dump_tainted_o), 0);
    sig_write(1, 64'hC, 64'hF0);
    tick();
    idle_bus();
    chk("s030_id3", 64'(dump_id_o), 3);
    chk("s030_v3", dump_value_o, 64'hC);
    chk("s030_t3", 64'(dump_tainted_o), 1);
    tick();
    chk("s030_empty", 64'(dump_valid_o), 0);

    // stream overflow while ready is low
    do_reset();
    start_run(0);
    sig_write(2, 64'h100, 0);
    tick(2);
    chk("s031_ovf0", 64'(overflow_o), 0);
    tick();
    idle_bus();
    chk("s031_ovf1", 64'(overflow_o), 1);
    chk("s031_head0", 64'(dump_id_o), 0);
    chk("s031_kind", 64'(dump_kind_o), 1);
    tick(2);
    chk("s031_hold", 64'(dump_id_o), 0);
    dump_ready_i = 1;
    tick();
    chk("s031_head1", 64'(dump_id_o), 1);
    tick();
    chk("s031_empty", 64'(dump_valid_o), 0);
    sig_write(2, 64'h200, 0);
    tick();
    idle_bus();
    chk("s031_id3", 64'(dump_id_o), 3);
    chk("s031_sticky", 64'(overflow_o), 1);

    // stop write coinciding with the SIMLEN limit
    do_reset();
    start_run(20);
    tick(19);
    sig_write(0, 0, 0);
    tick();
    idle_bus();
    chk("s032_state", 64'(state_o), 3);
    chk("s032_cause", 64'(done_cause_o), 1);
    chk("s032_step", 64'(step_o), 20);

    // reset during drain with two queued records
    do_reset();
    start_run(0);
    sig_write(1, 64'h11, 0);
    tick(2);
    sig_write(0, 0, 0);
    tick();
    idle_bus();
    chk("s033_drain", 64'(state_o), 2);
    chk("s033_valid", 64'(dump_valid_o), 1);
    rst_ni = 0;
    tick();
    chk("s033_rstate", 64'(state_o), 0);
    chk("s033_rvalid", 64'(dump_valid_o), 0);
    rst_ni = 1;
    start_run(0);
    sig_write(1, 64'h21, 0);
    tick();
    chk("s033_ireg_id", 64'(dump_id_o), 1);
    dump_ready_i = 1;
    sig_write(2, 64'h22, 0);
    tick();
    idle_bus();
    chk("s033_stream_id", 64'(dump_id_o), 0);
    chk("s033_stream_kind", 64'(dump_kind_o), 1);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sig_ctrl.md
SIG_CTRL -- requirements
Module: sig_ctrl

Interface
REQ-001 Parameters SHALL be ADDR_WIDTH=21 (mem address width), DATA_WIDTH=128 (mem data width), STOP_ADDR=0, IREG_ADDR=1, STREAM_ADDR=2 (word addresses of the signature registers), STOP_DRAIN=50 (cycles run after a stop request), CNT_WIDTH=32 (step counter width).
REQ-002 The clock and reset SHALL be: one clock; reset is synchronous and active-low. Ports: clk_i input 1 (sole clock, rising edge); rst_ni input 1 (synchronous, active-low).
REQ-003 run_en_i input 1: starts the run when high in IDLE.
REQ-004 simlen_i input CNT_WIDTH: cycle limit for the run; 0 means no limit.
REQ-005 mem_req_i, mem_we_i input 1 each: request and write enable from the SoC memory port.
REQ-006 mem_addr_i input ADDR_WIDTH; mem_wdata_i input DATA_WIDTH; mem_wdata_t0_i input DATA_WIDTH (taint of wdata).
REQ-007 dump_valid_o output 1; dump_ready_i input 1: valid/ready handshake for dump records.
REQ-008 dump_kind_o output 1 (0 = integer register, 1 = stream); dump_id_o output 8; dump_value_o output 64; dump_value_t0_o output 64; dump_tainted_o output 1 (OR of dump_value_t0_o).
REQ-009 Status outputs: state_o output 2; done_o output 1; done_cause_o output 1 (0 = stop request, 1 = SIMLEN); step_o output CNT_WIDTH; overflow_o output 1 (sticky).

Function
REQ-010 A "sig write" is a cycle with mem_req_i=1 and mem_we_i=1; the address compare uses all ADDR_WIDTH bits.
REQ-011 The FSM SHALL have states IDLE=0, RUN=1, DRAIN=2, DONE=3, with state_o equal to the current state.
REQ-012 Transition IDLE->RUN SHALL occur on the first edge with run_en_i=1; sig writes in IDLE are ignored.
REQ-013 In RUN and DRAIN, step_o SHALL increment by 1 per cycle, starting at 0 in the first RUN cycle.
REQ-014 With simlen_i!=0, the FSM SHALL go to DONE with cause 1 on the edge at which step_o==simlen_i-1, from either RUN or DRAIN.
REQ-015 A sig write to STOP_ADDR in RUN SHALL go RUN->DRAIN and load the drain counter with STOP_DRAIN; wdata is ignored.
REQ-016 In DRAIN the counter SHALL decrement each cycle. The edge at which it reads 0 SHALL go to DONE with cause 0, so done_o rises STOP_DRAIN+1 edges after the stop edge.
REQ-017 If the stop write and the SIMLEN limit occur in the same cycle, the FSM SHALL enter DONE with cause 1.
REQ-018 In RUN only, a sig write to IREG_ADDR or STREAM_ADDR SHALL enqueue the record {kind, id, wdata[63:0], wdata_t0[63:0]}. Such writes in DRAIN, DONE and IDLE are ignored.
REQ-019 The ireg id counter SHALL reset to 1 and the stream id counter to 0. Each counter increments by 1 mod 256 on every accepted write of its kind, whether or not the record was enqueued.
REQ-020 Records SHALL be buffered in a 2-entry FIFO with dump outputs driven from its head.
REQ-021 A dump write arriving with the FIFO full SHALL drop the record and set overflow_o until reset; a simultaneous pop frees a slot, so the write is accepted.
REQ-022 dump_valid_o SHALL equal FIFO not-empty. A record pops on an edge with valid && ready. Outputs SHALL hold stable while valid && !ready.
REQ-023 The FIFO SHALL keep draining in DRAIN and DONE.
REQ-024 done_o SHALL be 1 exactly in DONE. DONE is terminal until reset; step_o freezes.
REQ-025 Latency: a sig write sampled at edge k SHALL appear on dump outputs after edge k when the FIFO is empty (1 cycle).

Reset
REQ-026 On an rst_ni=0 edge: state=IDLE; step_o=0; drain counter=0; FIFO empty; dump_valid_o=0; dump_id_o, dump_value_o, dump_value_t0_o, dump_kind_o=0; done_o=0; done_cause_o=0; overflow_o=0; ireg id=1; stream id=0.
REQ-027 Reset asserted mid-run SHALL discard buffered records; rst_ni takes priority over all other inputs.

Verification
REQ-028 simlen_i=10, run_en_i pulse, no writes -> done_o=1 with cause 1 after edge with step_o=9; state_o=3.
REQ-029 simlen_i=0; stop write at step 5 -> state DRAIN; done_o rises 51 edges later; cause 0; IREG writes during DRAIN produce no records.
REQ-030 Three IREG writes (wdata low=0xA,0xB,0xC; t0=0x0,0x0,0xF0) with dump_ready_i=1 -> records ids 1,2,3, values 0xA,0xB,0xC; dump_tainted_o=1 only on id 3.
REQ-031 dump_ready_i=0; three STREAM writes -> ids 0,1 buffered, third dropped, overflow_o=1; next STREAM write after release gets id 3.
REQ-032 simlen_i=20, stop write at step 19 -> DONE cause 1 on that edge.
REQ-033 Assert rst_ni=0 during DRAIN with 2 records queued -> next cycle state_o=0, dump_valid_o=0, ids restored to 1/0.
